// File: rtl/sprite_layer_mixer.sv
// Player/enemy sprite mixer sharing one synchronous sprite ROM over two slots.
// Optional SPRITE_COLLISION_EN adds a per-frame player/enemy overlap flag.
module sprite_layer_mixer #(
  parameter int ROM_AW      = 17,
  parameter int ROM_DW      = 4,
  parameter int ROM_LATENCY = 1,
  parameter int ENEMY_BASE  = 30720,
  parameter logic [ROM_DW-1:0] TRANSPARENT = ROM_DW'(0)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Pix_En,
  input  logic              Frame_Start,
  input  logic              Player_Is_Obj,
  input  logic [15:0]       Player_Addr,
  input  logic              Enemy_Is_Obj,
  input  logic [15:0]       Enemy_Addr,
  input  logic [ROM_DW-1:0] Bg_Index,
  output logic [ROM_AW-1:0] Rom_Addr,
  input  logic [ROM_DW-1:0] Rom_Data,
  output logic [ROM_DW-1:0] Pixel_Index,
  output logic [1:0]        Pixel_Src,
  output logic              Pixel_Valid,
  output logic              Overrun,
  output logic              Collision
);

  localparam int L = ROM_LATENCY;

  typedef struct packed {
    logic              a;
    logic              b;
    logic              obj;
    logic [ROM_DW-1:0] bg;
  } tag_t;

  tag_t              tags [0:L];
  tag_t              td;
  logic              slot_a;
  logic              ovr;
  logic              accept;
  logic [15:0]       e_addr;
  logic              e_obj;
  logic [ROM_DW-1:0] e_bg;
  logic [ROM_DW-1:0] p_data;
  logic              p_opq;
  logic [ROM_DW-1:0] d_val;
  logic              d_opq;
  logic              hit;

  assign accept  = Pix_En & ~slot_a;
  assign Overrun = ovr | (Pix_En & slot_a);
  assign td      = tags[L];
  assign d_val   = td.obj ? Rom_Data : TRANSPARENT;
  assign d_opq   = d_val != TRANSPARENT;
  assign hit     = td.b & p_opq & d_opq;

  // Tags ride alongside each ROM cycle so returning data knows its slot.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Rom_Addr <= '0;
      slot_a   <= 1'b0;
      ovr      <= 1'b0;
      e_addr   <= '0;
      e_obj    <= 1'b0;
      e_bg     <= '0;
      for (int k = 0; k <= L; k++) tags[k] <= '0;
    end else begin
      slot_a <= accept;
      if (Pix_En && slot_a) ovr <= 1'b1;
      for (int k = 1; k <= L; k++) tags[k] <= tags[k-1];
      if (accept) begin
        Rom_Addr <= Player_Is_Obj ? ROM_AW'(Player_Addr) : '0;
        tags[0]  <= '{a: 1'b1, b: 1'b0, obj: Player_Is_Obj, bg: '0};
        e_addr   <= Enemy_Addr;
        e_obj    <= Enemy_Is_Obj;
        e_bg     <= Bg_Index;
      end else if (slot_a) begin
        Rom_Addr <= e_obj ? ROM_AW'(e_addr) + ROM_AW'(ENEMY_BASE) : '0;
        tags[0]  <= '{a: 1'b0, b: 1'b1, obj: e_obj, bg: e_bg};
      end else begin
        Rom_Addr <= '0;
        tags[0]  <= '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p_data      <= '0;
      p_opq       <= 1'b0;
      Pixel_Index <= '0;
      Pixel_Src   <= 2'd0;
      Pixel_Valid <= 1'b0;
    end else begin
      Pixel_Valid <= td.b;
      if (td.a) begin
        p_data <= d_val;
        p_opq  <= d_opq;
      end
      if (td.b) begin
        if (p_opq) begin
          Pixel_Index <= p_data;
          Pixel_Src   <= 2'd2;
        end else if (d_opq) begin
          Pixel_Index <= d_val;
          Pixel_Src   <= 2'd1;
        end else begin
          Pixel_Index <= td.bg;
          Pixel_Src   <= 2'd0;
        end
      end
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [16:0] coll_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      coll_cnt  <= '0;
      Collision <= 1'b0;
    end else if (Frame_Start) begin
      Collision <= coll_cnt != '0;
      coll_cnt  <= hit ? 17'd1 : 17'd0;
    end else if (hit && coll_cnt != '1) begin
      coll_cnt <= coll_cnt + 17'd1;
    end
  end
`else
  logic unused_frame;
  assign unused_frame = Frame_Start ^ hit;
  assign Collision    = 1'b0;
`endif

endmodule
